sdram_slot_arbiter: RTL and testbench
=====================================

Name: sdram_slot_arbiter

Overview:
- Upstream request stage for the 96 MHz SDRAM controller. Arbitrates between a CPU port (16-bit read/write) and a video port (64-bit burst read).
- Presents one request per 8 MHz chipset slot on the controller's req/we/addr/ds/din inputs and holds it stable for the whole slot.
- Captures the controller's dout/dout64 at the following slot boundary and returns the data to the owning client with a one-cycle ack.

Parameters:
- CPU_MAX_WAIT, 3: consecutive lost slots after which a pending CPU request overrides video priority.
- WAIT_W, 2: width of the CPU wait counter; must hold CPU_MAX_WAIT.

Ports:
- clk_96  in  1  system clock, 96 MHz.
- init  in  1  reset; one clock, synchronous, active-high.
- clk_8_en  in  1  8 MHz chipset phase; a slot starts on its rising edge.
- cpu_req  in  1  CPU request; held with fields stable until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  24  word address.
- cpu_ds  in  2  byte strobes for writes.
- cpu_din  in  16  write data.
- cpu_dout  out  16  read data; valid when cpu_ack pulses, held until the next CPU read retires.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  video burst request; held until vid_ack.
- vid_addr  in  24  word address; bits [1:0] are ignored and forced to 0.
- vid_dout  out  64  burst data; valid at vid_ack, held until the next video retire.
- vid_ack  out  1  one-cycle completion pulse.
- sd_req  out  1  to controller req.
- sd_we  out  1  to controller we.
- sd_addr  out  24  to controller addr.
- sd_ds  out  2  to controller ds.
- sd_din  out  16  to controller din.
- sd_dout  in  16  from controller dout.
- sd_dout64  in  64  from controller dout64.

Behaviour:
- Edge detect: clk_8_en_d is registered every cycle. slot_start = clk_8_en & ~clk_8_en_d. One slot = 12 clk_96 cycles.
- State: owner ∈ {NONE, CPU, VID} (2 bits), owner_we, cpu_wait[WAIT_W-1:0].
- Reset (init=1): all outputs 0, owner=NONE, cpu_wait=0, clk_8_en_d=0. Reset mid-slot discards the in-flight owner: no ack is ever issued for it, and sd_req is 0 on the cycle after init is sampled.
- On slot_start, first retire:
  - owner=CPU: cpu_ack=1 for this cycle. If !owner_we, cpu_dout <= sd_dout.
  - owner=VID: vid_ack=1 for this cycle and vid_dout <= sd_dout64.
  - owner=NONE: no ack.
- In the same cycle, grant. The client being retired is excluded because its req is still high.
  - CPU eligible = cpu_req & owner!=CPU. VID eligible = vid_req & owner!=VID.
  - Both eligible: VID wins unless cpu_wait >= CPU_MAX_WAIT, in which case CPU wins.
  - Only one eligible: that client wins. Neither: owner=NONE, sd_req=0, and the controller refreshes.
- Drive on grant, registered and taking effect the cycle after slot_start:
  - CPU: sd_req=1, sd_we=cpu_we, sd_addr=cpu_addr, sd_ds=cpu_ds, sd_din=cpu_din, owner_we=cpu_we.
  - VID: sd_req=1, sd_we=0, sd_addr={vid_addr[23:2],2'b00}, sd_ds=2'b11, sd_din=0, owner_we=0.
- sd_* outputs and owner change only on slot_start or init.
- cpu_wait:
  - Cleared on a CPU grant, or when the CPU is not eligible at slot_start.
  - Incremented when the CPU is eligible but VID wins.
  - Saturates at CPU_MAX_WAIT; no wrap.
- Latency: a request asserted before slot_start k is granted at k and acked at slot_start k+1, i.e. 12–24 cycles from assertion when uncontended.
- Back-to-back: a client that drops req on its ack may re-assert on the next cycle. It is then eligible at the following slot_start, so at most every other slot.
- Ack pulses are exactly one cycle wide. cpu_ack and vid_ack are never high in the same cycle.
- Changing clk_8_en phase mid-slot simply starts a new slot at the next detected rising edge.

Test Plan:
- CPU read: idle, cpu_req=1, cpu_addr=0x000123, we=0; sd_dout=0xBEEF at the next boundary -> sd_req=1, sd_addr=0x000123, sd_we=0 for 12 cycles; cpu_ack for 1 cycle at the next slot_start; cpu_dout=0xBEEF.
- CPU write: cpu_we=1, cpu_ds=2'b01, cpu_din=0x55AA -> sd_we=1, sd_ds=2'b01, sd_din=0x55AA for one slot; cpu_ack next boundary; cpu_dout unchanged.
- Contention: cpu_req and vid_req (vid_addr=0x00ABC7) rise together -> slot k: sd_addr=0x00ABC4, sd_we=0; at k+1 vid_ack with vid_dout=sd_dout64=0x0123456789ABCDEF, and CPU granted in slot k+1; cpu_ack at k+2.
- Starvation: vid_req re-asserted immediately after each ack and cpu_req held -> video holds alternate slots; CPU is granted no later than its 4th eligible slot (CPU_MAX_WAIT=3); cpu_wait never exceeds 3.
- Idle: no requests for 10 slots -> sd_req=0 throughout, no acks, owner=NONE.
- Reset mid-op: CPU read granted, init=1 for 2 cycles at cycle 5 of the slot -> all outputs 0, no cpu_ack at the next boundary; after init=0 with cpu_req still high, the request is granted at the next slot_start.

Source files
------------

// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter in front of the 96 MHz SDRAM controller: one CPU or video request
// per 8 MHz chipset slot, data returned to the owner at the following slot boundary.
module sdram_slot_arbiter #(
  parameter int CPU_MAX_WAIT = 3,
  parameter int WAIT_W       = 2
) (
  input  logic              clk_96,
  input  logic              init,
  input  logic              clk_8_en,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [23:0]       cpu_addr,
  input  logic [1:0]        cpu_ds,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [23:0]       vid_addr,
  output logic [63:0]       vid_dout,
  output logic              vid_ack,
  output logic              sd_req,
  output logic              sd_we,
  output logic [23:0]       sd_addr,
  output logic [1:0]        sd_ds,
  output logic [15:0]       sd_din,
  input  logic [15:0]       sd_dout,
  input  logic [63:0]       sd_dout64,
  output logic [1:0]        dbg_owner_o,
  output logic [WAIT_W-1:0] dbg_cpu_wait_o
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VID  = 2'd2;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  logic              clk8_q;
  logic [1:0]        owner_q, owner_d;
  logic              owner_we_q, owner_we_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              sd_req_q, sd_req_d;
  logic              sd_we_q, sd_we_d;
  logic [23:0]       sd_addr_q, sd_addr_d;
  logic [1:0]        sd_ds_q, sd_ds_d;
  logic [15:0]       sd_din_q, sd_din_d;
  logic [15:0]       cpu_dout_q, cpu_dout_d;
  logic [63:0]       vid_dout_q, vid_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;

  logic slot_start;
  logic cpu_elig, vid_elig, cpu_win, vid_win;
  logic unused_vid_lsb;

  assign slot_start = clk_8_en & ~clk8_q;
  // The client currently being retired still has req high, so it is excluded.
  assign cpu_elig   = cpu_req && (owner_q != OWN_CPU);
  assign vid_elig   = vid_req && (owner_q != OWN_VID);
  assign cpu_win    = cpu_elig && (!vid_elig || (wait_q >= WAIT_MAX));
  assign vid_win    = vid_elig && !cpu_win;
  assign unused_vid_lsb = ^vid_addr[1:0];

  always_comb begin
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    wait_d     = wait_q;
    sd_req_d   = sd_req_q;
    sd_we_d    = sd_we_q;
    sd_addr_d  = sd_addr_q;
    sd_ds_d    = sd_ds_q;
    sd_din_d   = sd_din_q;
    cpu_dout_d = cpu_dout_q;
    vid_dout_d = vid_dout_q;
    cpu_ack_d  = 1'b0;
    vid_ack_d  = 1'b0;
    if (slot_start) begin
      if (owner_q == OWN_CPU) begin
        cpu_ack_d = 1'b1;
        if (!owner_we_q) cpu_dout_d = sd_dout;
      end
      if (owner_q == OWN_VID) begin
        vid_ack_d  = 1'b1;
        vid_dout_d = sd_dout64;
      end
      if (cpu_win) begin
        owner_d    = OWN_CPU;
        owner_we_d = cpu_we;
        sd_req_d   = 1'b1;
        sd_we_d    = cpu_we;
        sd_addr_d  = cpu_addr;
        sd_ds_d    = cpu_ds;
        sd_din_d   = cpu_din;
      end else if (vid_win) begin
        owner_d    = OWN_VID;
        owner_we_d = 1'b0;
        sd_req_d   = 1'b1;
        sd_we_d    = 1'b0;
        sd_addr_d  = {vid_addr[23:2], 2'b00};
        sd_ds_d    = 2'b11;
        sd_din_d   = 16'h0000;
      end else begin
        // Empty slot: the controller uses it for refresh.
        owner_d    = OWN_NONE;
        owner_we_d = 1'b0;
        sd_req_d   = 1'b0;
        sd_we_d    = 1'b0;
        sd_addr_d  = 24'h000000;
        sd_ds_d    = 2'b00;
        sd_din_d   = 16'h0000;
      end
      if (cpu_win || !cpu_elig) wait_d = '0;
      else if (wait_q < WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_96) begin
    if (init) begin
      clk8_q     <= 1'b0;
      owner_q    <= OWN_NONE;
      owner_we_q <= 1'b0;
      wait_q     <= '0;
      sd_req_q   <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= 24'h000000;
      sd_ds_q    <= 2'b00;
      sd_din_q   <= 16'h0000;
      cpu_dout_q <= 16'h0000;
      vid_dout_q <= 64'h0;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
    end else begin
      clk8_q     <= clk_8_en;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      wait_q     <= wait_d;
      sd_req_q   <= sd_req_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_ds_q    <= sd_ds_d;
      sd_din_q   <= sd_din_d;
      cpu_dout_q <= cpu_dout_d;
      vid_dout_q <= vid_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_ack_q  <= vid_ack_d;
    end
  end

  assign sd_req         = sd_req_q;
  assign sd_we          = sd_we_q;
  assign sd_addr        = sd_addr_q;
  assign sd_ds          = sd_ds_q;
  assign sd_din         = sd_din_q;
  assign cpu_dout       = cpu_dout_q;
  assign cpu_ack        = cpu_ack_q;
  assign vid_dout       = vid_dout_q;
  assign vid_ack        = vid_ack_q;
  assign dbg_owner_o    = owner_q;
  assign dbg_cpu_wait_o = wait_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: directed scenarios then randomized traffic, all
// checked against a slot-level reference model and ack-data scoreboard queues.
module tb_sdram_slot_arbiter;

  localparam int CPU_MAX_WAIT = 3;
  localparam int WAIT_W       = 2;

  logic        clk_96, init, clk_8_en;
  logic        cpu_req, cpu_we;
  logic [23:0] cpu_addr;
  logic [1:0]  cpu_ds;
  logic [15:0] cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic [63:0] vid_dout;
  logic        vid_ack;
  logic        sd_req, sd_we;
  logic [23:0] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_din, sd_dout;
  logic [63:0] sd_dout64;
  logic [1:0]  dbg_owner;
  logic [WAIT_W-1:0] dbg_cpu_wait;

  sdram_slot_arbiter #(.CPU_MAX_WAIT(CPU_MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk_96(clk_96), .init(init), .clk_8_en(clk_8_en),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_ds(sd_ds), .sd_din(sd_din),
    .sd_dout(sd_dout), .sd_dout64(sd_dout64),
    .dbg_owner_o(dbg_owner), .dbg_cpu_wait_o(dbg_cpu_wait)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // ---------------- clock / watchdog ----------------
  initial begin
    clk_96 = 1'b0;
    forever #5 clk_96 = ~clk_96;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus knobs ----------------
  int          ph = 11;
  int          jump_pct = 0;
  int          cpu_pct = 0, vid_pct = 0, vid_hold = 0;
  bit          cpu_rand = 0, dout_rand = 0;
  logic        fix_we = 1'b0;
  logic [23:0] fix_addr = 24'h0, fix_vaddr = 24'h0;
  logic [1:0]  fix_ds = 2'b11;
  logic [15:0] fix_din = 16'h0, fix_dout = 16'h0;
  logic [63:0] fix_dout64 = 64'h0;

  // Driver: chipset phase, controller data, and two clients that hold req until ack.
  initial begin
    clk_8_en = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_ds = '0;
    cpu_din = '0; vid_req = 1'b0; vid_addr = '0; sd_dout = '0; sd_dout64 = '0;
    forever begin
      @(negedge clk_96);
      ph = (ph == 11) ? 0 : ph + 1;
      if (jump_pct != 0 && $urandom_range(0, 999) < jump_pct) ph = $urandom_range(0, 11);
      clk_8_en = (ph < 6);
      if (dout_rand) begin
        sd_dout   = 16'($urandom);
        sd_dout64 = {$urandom, $urandom};
      end else begin
        sd_dout   = fix_dout;
        sd_dout64 = fix_dout64;
      end
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 99) < cpu_pct) begin
        cpu_req = 1'b1;
        if (cpu_rand) begin
          cpu_we   = 1'($urandom_range(0, 1));
          cpu_addr = 24'($urandom);
          cpu_ds   = 2'($urandom_range(0, 3));
          cpu_din  = 16'($urandom);
        end else begin
          cpu_we = fix_we; cpu_addr = fix_addr; cpu_ds = fix_ds; cpu_din = fix_din;
        end
      end
      if (vid_req && vid_ack && $urandom_range(0, 99) >= vid_hold) vid_req = 1'b0;
      else if (!vid_req && $urandom_range(0, 99) < vid_pct) begin
        vid_req  = 1'b1;
        vid_addr = cpu_rand ? 24'($urandom) : fix_vaddr;
      end
    end
  end

  // ---------------- reference model ----------------
  // Slot-level rules: retire the previous owner, then pick the next one.
  bit          m_prev8 = 0;
  int          m_owner = 0;      // 0 none, 1 cpu, 2 video
  bit          m_owner_we = 0;
  int          m_wait = 0;
  bit          m_sd_req = 0, m_sd_we = 0;
  logic [23:0] m_sd_addr = '0;
  logic [1:0]  m_sd_ds = '0;
  logic [15:0] m_sd_din = '0, m_cpu_dout = '0;
  logic [63:0] m_vid_dout = '0;
  bit          m_cpu_ack = 0, m_vid_ack = 0;
  logic [15:0] exp_cpu_q[$];
  logic [63:0] exp_vid_q[$];

  task automatic model_step();
    bit ss, ce, ve;
    int win;
    ss = clk_8_en && !m_prev8;
    m_cpu_ack = 0;
    m_vid_ack = 0;
    if (init) begin
      m_prev8 = 0; m_owner = 0; m_owner_we = 0; m_wait = 0;
      m_sd_req = 0; m_sd_we = 0; m_sd_addr = '0; m_sd_ds = '0; m_sd_din = '0;
      m_cpu_dout = '0; m_vid_dout = '0;
      return;
    end
    m_prev8 = clk_8_en;
    if (!ss) return;
    if (m_owner == 1) begin
      m_cpu_ack = 1;
      if (!m_owner_we) m_cpu_dout = sd_dout;
      exp_cpu_q.push_back(m_cpu_dout);
    end else if (m_owner == 2) begin
      m_vid_ack  = 1;
      m_vid_dout = sd_dout64;
      exp_vid_q.push_back(m_vid_dout);
    end
    ce = cpu_req && m_owner != 1;
    ve = vid_req && m_owner != 2;
    if (ce && (!ve || m_wait >= CPU_MAX_WAIT)) win = 1;
    else if (ve) win = 2;
    else win = 0;
    if (win == 1 || !ce) m_wait = 0;
    else m_wait = (m_wait + 1 > CPU_MAX_WAIT) ? CPU_MAX_WAIT : m_wait + 1;
    m_owner = win;
    case (win)
      1: begin
        m_owner_we = cpu_we; m_sd_req = 1; m_sd_we = cpu_we; m_sd_addr = cpu_addr;
        m_sd_ds = cpu_ds; m_sd_din = cpu_din;
      end
      2: begin
        m_owner_we = 0; m_sd_req = 1; m_sd_we = 0; m_sd_addr = {vid_addr[23:2], 2'b00};
        m_sd_ds = 2'b11; m_sd_din = '0;
      end
      default: begin
        m_owner_we = 0; m_sd_req = 0; m_sd_we = 0; m_sd_addr = '0; m_sd_ds = '0; m_sd_din = '0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk_96);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle checker: every DUT output against the model.
  initial forever begin
    @(negedge clk_96);
    if (chk_on) begin
      check("sd_req",   64'(sd_req),       64'(m_sd_req));
      check("sd_we",    64'(sd_we),        64'(m_sd_we));
      check("sd_addr",  64'(sd_addr),      64'(m_sd_addr));
      check("sd_ds",    64'(sd_ds),        64'(m_sd_ds));
      check("sd_din",   64'(sd_din),       64'(m_sd_din));
      check("cpu_ack",  64'(cpu_ack),      64'(m_cpu_ack));
      check("vid_ack",  64'(vid_ack),      64'(m_vid_ack));
      check("owner",    64'(dbg_owner),    64'(m_owner));
      check("cpu_wait", 64'(dbg_cpu_wait), 64'(m_wait));
    end
  end

  // Data monitor: pops the expected queue whenever the DUT acks.
  initial forever begin
    @(negedge clk_96);
    if (chk_on) begin
      if (cpu_ack && vid_ack) check("ack_exclusive", 64'(cpu_ack & vid_ack), 64'(0));
      if (cpu_ack) begin
        if (exp_cpu_q.size() == 0) check("cpu_ack_unexpected", 64'(cpu_ack), 64'(0));
        else check("cpu_dout", 64'(cpu_dout), 64'(exp_cpu_q.pop_front()));
      end
      if (vid_ack) begin
        if (exp_vid_q.size() == 0) check("vid_ack_unexpected", 64'(vid_ack), 64'(0));
        else check("vid_dout", vid_dout, exp_vid_q.pop_front());
      end
    end
  end

  // which: 0 cpu_ack, 1 vid_ack, 2 sd_req
  task automatic wait_sig(input int which, input int budget, input string nm, output int n);
    bit hit;
    hit = 0;
    n = 0;
    while (n < budget && !hit) begin
      @(posedge clk_96); #1;
      n++;
      case (which)
        0:       hit = cpu_ack;
        1:       hit = vid_ack;
        default: hit = sd_req;
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: no event within %0d cycles, event required", nm, budget);
    end
  endtask

  task automatic do_init(input int cycles);
    @(negedge clk_96); init = 1'b1;
    repeat (cycles) @(negedge clk_96);
    init = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int n, n_req, n_ack, cpu_served;

  initial begin
    init = 1'b1;
    repeat (3) @(posedge clk_96);
    #1;
    chk_on = 1;
    check("rst_cpu_dout", 64'(cpu_dout), 64'(0));
    check("rst_vid_dout", vid_dout, 64'(0));
    check("rst_sd_req",   64'(sd_req), 64'(0));
    @(negedge clk_96); init = 1'b0;
    repeat (30) @(posedge clk_96);

    // CPU read
    fix_we = 1'b0; fix_addr = 24'h000123; fix_ds = 2'b11; fix_din = 16'h0;
    fix_dout = 16'hBEEF; cpu_pct = 100;
    wait_sig(2, 40, "rd_grant", n);
    check("rd_sd_addr", 64'(sd_addr), 64'(24'h000123));
    check("rd_sd_we",   64'(sd_we),   64'(0));
    wait_sig(0, 40, "rd_ack", n);
    cpu_pct = 0;
    check("rd_ack_latency", 64'(n), 64'(12));
    check("rd_cpu_dout", 64'(cpu_dout), 64'(16'hBEEF));

    // CPU write
    fix_we = 1'b1; fix_addr = 24'h000200; fix_ds = 2'b01; fix_din = 16'h55AA;
    fix_dout = 16'h1111; cpu_pct = 100;
    wait_sig(2, 40, "wr_grant", n);
    check("wr_sd_we",  64'(sd_we),  64'(1));
    check("wr_sd_ds",  64'(sd_ds),  64'(2'b01));
    check("wr_sd_din", 64'(sd_din), 64'(16'h55AA));
    wait_sig(0, 40, "wr_ack", n);
    cpu_pct = 0;
    check("wr_cpu_dout_held", 64'(cpu_dout), 64'(16'hBEEF));

    // Contention: video first, then CPU in the next slot
    fix_we = 1'b0; fix_addr = 24'h000321; fix_vaddr = 24'h00ABC7;
    fix_dout = 16'hCAFE; fix_dout64 = 64'h0123456789ABCDEF;
    repeat (20) @(posedge clk_96);
    cpu_pct = 100; vid_pct = 100;
    wait_sig(2, 40, "ct_grant", n);
    check("ct_sd_addr", 64'(sd_addr), 64'(24'h00ABC4));
    check("ct_sd_we",   64'(sd_we),   64'(0));
    check("ct_owner_vid", 64'(dbg_owner), 64'(2));
    wait_sig(1, 40, "ct_vid_ack", n);
    vid_pct = 0;
    check("ct_vid_dout", vid_dout, 64'h0123456789ABCDEF);
    check("ct_cpu_next", 64'(sd_addr), 64'(24'h000321));
    wait_sig(0, 40, "ct_cpu_ack", n);
    cpu_pct = 0;
    check("ct_cpu_dout", 64'(cpu_dout), 64'(16'hCAFE));

    // Starvation attempt: video always re-requests, CPU always pending
    cpu_rand = 1; dout_rand = 1; cpu_pct = 100; vid_pct = 100; vid_hold = 100;
    cpu_served = 0;
    repeat (360) begin
      @(posedge clk_96); #1;
      if (cpu_ack) cpu_served++;
      if (dbg_cpu_wait > WAIT_W'(CPU_MAX_WAIT)) check("starve_wait_bound", 64'(dbg_cpu_wait), 64'(CPU_MAX_WAIT));
    end
    check("starve_cpu_served", 64'(cpu_served >= 8), 64'(1));
    cpu_pct = 0; vid_pct = 0; vid_hold = 0;
    repeat (96) @(posedge clk_96);

    // Idle
    n_req = 0; n_ack = 0;
    repeat (120) begin
      @(posedge clk_96); #1;
      if (sd_req) n_req++;
      if (cpu_ack || vid_ack) n_ack++;
    end
    check("idle_sd_req", 64'(n_req), 64'(0));
    check("idle_acks",   64'(n_ack), 64'(0));
    check("idle_owner",  64'(dbg_owner), 64'(0));

    // Reset in the middle of a granted CPU read
    cpu_rand = 0; dout_rand = 0; fix_we = 1'b0; fix_addr = 24'h000456; fix_dout = 16'h7777;
    cpu_pct = 100;
    wait_sig(2, 40, "rst_grant", n);
    while (ph != 4) @(posedge clk_96);
    @(negedge clk_96); init = 1'b1;
    @(posedge clk_96); #1;
    check("rst_mid_sd_req", 64'(sd_req), 64'(0));
    check("rst_mid_dout",   64'(cpu_dout), 64'(0));
    @(negedge clk_96);
    @(negedge clk_96); init = 1'b0;
    wait_sig(0, 40, "rst_regrant_ack", n);
    cpu_pct = 0;
    check("rst_no_early_ack", 64'(n > 12), 64'(1));
    check("rst_regrant_dout", 64'(cpu_dout), 64'(16'h7777));

    // Randomized traffic with phase jumps and occasional resets
    cpu_rand = 1; dout_rand = 1; jump_pct = 3;
    for (int blk = 0; blk < 20; blk++) begin
      cpu_pct  = $urandom_range(0, 100);
      vid_pct  = $urandom_range(0, 100);
      vid_hold = $urandom_range(0, 60);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk_96);
        if ($urandom_range(0, 999) < 2) do_init($urandom_range(1, 2));
      end
    end
    cpu_pct = 0; vid_pct = 0; vid_hold = 0; jump_pct = 0;
    repeat (96) @(posedge clk_96);
    #1;
    check("exp_cpu_q_empty", 64'(exp_cpu_q.size()), 64'(0));
    check("exp_vid_q_empty", 64'(exp_vid_q.size()), 64'(0));

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
